// File: rtl/instr_pkg.sv
// Shared instruction kinds, MIPS opcode/funct constants and field packers.
// Also used by the pipeline's control decoder so both sides agree on encodings.
package instr_pkg;

  typedef enum logic [3:0] {
    K_NOP = 4'd0,
    K_ADD = 4'd1,
    K_SUB = 4'd2,
    K_JR  = 4'd3,
    K_LW  = 4'd4,
    K_SW  = 4'd5,
    K_BEQ = 4'd6,
    K_ORI = 4'd7,
    K_LUI = 4'd8,
    K_JAL = 4'd9
  } instr_kind_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FULL = 1'b1
  } wr_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_JR  = 6'h08;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: symbolic instruction kind plus fields to a 32-bit MIPS word.
// Kinds outside the table raise illegal and produce an all-zero word.
module instr_encode
  import instr_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (kind)
      K_NOP:   word = 32'd0;
      K_ADD:   word = enc_r(rs, rt, rd, FN_ADD);
      K_SUB:   word = enc_r(rs, rt, rd, FN_SUB);
      K_JR:    word = enc_r(rs, 5'd0, 5'd0, FN_JR);
      K_LW:    word = enc_i(OP_LW, rs, rt, imm);
      K_SW:    word = enc_i(OP_SW, rs, rt, imm);
      K_BEQ:   word = enc_i(OP_BEQ, rs, rt, imm);
      K_ORI:   word = enc_i(OP_ORI, rs, rt, imm);
      K_LUI:   word = enc_i(OP_LUI, 5'd0, rt, imm);
      K_JAL:   word = {OP_JAL, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_writer.sv
// Sequential program loader: accepts encoded requests and strobes them into
// instruction memory one cycle later at consecutive word addresses from BASE_ADDR.
module instr_writer
  import instr_pkg::*;
#(
  parameter int          IM_DEPTH  = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rewind,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_kind,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  output logic                     im_we,
  output logic [31:0]              im_addr,
  output logic [31:0]              im_wdata,
  output logic [$clog2(IM_DEPTH):0] count,
  output logic                     full,
  output logic                     err,
  output wr_state_e                dbg_state
);

  localparam int PW = $clog2(IM_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IM_DEPTH);

  // Handshake: a request transfers on any cycle with in_valid && in_ready;
  // in_ready never depends on in_valid.
  wr_state_e      state_q, state_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;

  logic [31:0]    enc_word;
  logic           enc_illegal;
  logic           full_next;
  logic           accept;
  logic [PW-1:0]  next_ptr;

  instr_encode u_encode (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .target  (in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Counting the in-flight strobe lets back-to-back accepts stop exactly at capacity.
  assign full_next = (count_q + CW'(we_q)) == DEPTH_C;
  assign in_ready  = !reset && !rewind && (state_q == ST_RUN) && !full_next;
  assign accept    = in_valid && in_ready;
  assign next_ptr  = wptr_q + PW'(we_q);

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    err_d   = err_q;

    if (we_q) begin
      wptr_d  = wptr_q + PW'(1);
      count_d = count_q + CW'(1);
      if ((count_q + CW'(1)) == DEPTH_C) state_d = ST_FULL;
    end

    if (accept) begin
      if (enc_illegal) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = BASE_ADDR + (32'(next_ptr) << 2);
        wdata_d = enc_word;
      end
    end

    // Rewind restarts the program image but keeps the sticky error.
    if (rewind) begin
      state_d = ST_RUN;
      we_d    = 1'b0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // A strobe already registered is suppressed if reset or rewind lands on it.
  assign im_we     = we_q && !reset && !rewind;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign count     = count_q;
  assign full      = (state_q == ST_FULL);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/instr_writer.md
# instr_writer

Program loader for the P5 pipeline's instruction memory. Accepts symbolic instruction requests (kind plus register/immediate fields) over a valid/ready handshake, encodes each into a 32-bit MIPS word (the inverse of the control decoder), and writes the words sequentially into instruction memory starting at the text base. Used by the testbench and boot path to build programs without a hand assembler.

## Interface
- IM_DEPTH, 4096: instruction-memory capacity in words; power of two, ≥2.
- BASE_ADDR, 32'h0000_3000: byte address of the first written word.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- rewind  in  1  synchronous; restarts writing at BASE_ADDR.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_kind  in  4  0 NOP, 1 ADD, 2 SUB, 3 JR, 4 LW, 5 SW, 6 BEQ, 7 ORI, 8 LUI, 9 JAL; 10–15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate/offset.
- in_target  in  26  JAL word target.
- im_we  out  1  one-cycle write strobe.
- im_addr  out  32  byte address of the write.
- im_wdata  out  32  encoded word.
- count  out  $clog2(IM_DEPTH)+1  words written since reset/rewind.
- full  out  1  count == IM_DEPTH.
- err  out  1  sticky: an illegal kind was consumed.

## Operation
- Accept occurs on a cycle with in_valid && in_ready. in_ready = !reset && !rewind && !full_next, where full_next means count plus the pending write equals IM_DEPTH.
- Encoding (all unused fields 0):
  - R-type: op 0, rs, rt, rd, shamt 0. Funct is 0x20 for ADD, 0x22 for SUB, 0x08 for JR (JR has rt=rd=0).
  - I-type: op rs rt imm. Opcodes are LW 0x23, SW 0x2B, BEQ 0x04, ORI 0x0D, LUI 0x0F (LUI has rs=0).
  - JAL: op 0x03 with in_target.
  - NOP: 32'h0, which is written and counted.
- An illegal kind is consumed: no write occurs, count is unchanged, and err is set. err clears only on reset; rewind does not clear it.
- Write pointer wptr:
  - im_addr = BASE_ADDR + {wptr, 2'b00}.
  - wptr and count increment on each issued write.
  - wptr width is $clog2(IM_DEPTH). No wrap is reachable because acceptance stops at full.
- States:
  - RUN: accepting requests.
  - FULL: entered when the write that makes count == IM_DEPTH issues. In FULL, in_ready = 0 and full = 1.
  - Exit from FULL only via rewind or reset, both of which go to RUN.
- Rewind:
  - Clears wptr, count, full, and the pending write. A pending encoded word not yet strobed is dropped.
  - Rewind and in_valid in the same cycle: in_ready = 0, so nothing is accepted.

## Timing
- Reset values: in_ready 0 during reset and 1 the next cycle. im_we 0, im_addr BASE_ADDR, im_wdata 0, count 0, full 0, err 0. State is RUN.
- Latency: im_we is asserted exactly 1 cycle after accept, with im_addr and im_wdata valid in that same cycle. count updates on the clock edge at the end of that strobe cycle.
- Throughput is one request per cycle. Back-to-back accepts yield consecutive strobes at consecutive addresses.
- im_we is a single-cycle pulse per write. im_addr and im_wdata hold their last values when im_we = 0.
- The accept that fills the last slot drops in_ready combinationally in the following cycle, during the final strobe.
- Reset mid-stream drops any pending write, and no strobe follows.

## Structure
- Shared package instr_pkg holds:
  - the in_kind enum;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ORI, OP_LUI, OP_JAL;
  - funct constants FN_ADD, FN_SUB, FN_JR.
- The Controller decoder uses the same package constants.
- Sub-module instr_encode is purely combinational: kind plus fields in, 32-bit word plus an illegal flag out.
- instr_writer holds:
  - the accept/write pipeline register;
  - wptr and count;
  - the RUN/FULL state;
  - the sticky err flag.

## Test plan
- After reset, send ORI rs=0 rt=1 imm=0x1234, then ADD rs=1 rt=2 rd=3 back-to-back. Required: strobes on consecutive cycles with 0x34011234 @0x3000 and 0x00221820 @0x3004; count = 2.
- Send LW rs=1 rt=4 imm=8, then JR rs=31, then LUI rt=5 imm=0xABCD. Required: words 0x8C240008, 0x03E00008, 0x3C05ABCD at 0x3000/4/8.
- Send JAL target=0x000C00. Required: 0x0C000C00; one cycle from accept to im_we.
- Send kind=12, then NOP. Required: no strobe for kind 12 and err = 1; NOP writes 0x00000000 @0x3000; count = 1; err stays 1 after a rewind.
- With IM_DEPTH=4, hold in_valid for 6 cycles. Required: exactly 4 strobes @0x3000–0x300C; full = 1; in_ready = 0; then rewind → count = 0, next write @0x3000.
- Accept a request and assert reset on the following cycle. Required: no im_we; all outputs at reset values.
